// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared definitions for the D-stage hazard scoreboard:
//   - register address / TUse / TNew widths and the "operand not read" code
//   - forward-select encodings driven to the D-stage operand muxes
//   - layout of one in-flight stage entry (E, M, W)
//   - control-word bit positions of TUseRs, TUseRt and TNew
//   - saturating TNew countdown helpers used when entries advance
// Optional feature macro used by the files importing this package:
//   MDU_STALL_EN (multiply/divide unit busy stall)
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    localparam int REG_AW = 5;
    localparam int T_W    = 3;

    localparam logic [T_W-1:0] TUSE_NONE = T_W'(7);

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] a3;
        logic [T_W-1:0]    tnew;
    } stage_entry_t;

    // Bit positions inside the D-stage control word.
    localparam int CW_TUSE_RS_HI = 16;
    localparam int CW_TUSE_RS_LO = 14;
    localparam int CW_TUSE_RT_HI = 13;
    localparam int CW_TUSE_RT_LO = 11;
    localparam int CW_TNEW_HI    = 10;
    localparam int CW_TNEW_LO    = 8;

    // TNew counts down once per stage advance and sticks at zero.
    function automatic logic [T_W-1:0] tnew_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - T_W'(1);
    endfunction

    function automatic stage_entry_t stage_advance(input stage_entry_t e);
        stage_entry_t r;
        r       = e;
        r.tnew  = tnew_dec(e.tnew);
        return r;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
// Bundle between the D-stage pipeline register (master) and the hazard
// scoreboard (slave).
//   master drives : RsD, RtD, TUseRsD, TUseRtD, RegWriteD, A3D, TNewD
//                   (+ MdD, MdStartE, MdBusyE when MDU_STALL_EN is defined)
//   master reads  : Stall, FwdRsD, FwdRtD
// Optional feature macro: MDU_STALL_EN
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if;
    import hazard_scoreboard_pkg::*;

    logic [REG_AW-1:0] RsD;
    logic [REG_AW-1:0] RtD;
    logic [T_W-1:0]    TUseRsD;
    logic [T_W-1:0]    TUseRtD;
    logic              RegWriteD;
    logic [REG_AW-1:0] A3D;
    logic [T_W-1:0]    TNewD;
    logic              Stall;
    logic [1:0]        FwdRsD;
    logic [1:0]        FwdRtD;
`ifdef MDU_STALL_EN
    logic              MdD;
    logic              MdStartE;
    logic              MdBusyE;
`endif

    modport master (
        output RsD, RtD, TUseRsD, TUseRtD, RegWriteD, A3D, TNewD,
`ifdef MDU_STALL_EN
        output MdD, MdStartE, MdBusyE,
`endif
        input  Stall, FwdRsD, FwdRtD
    );

    modport slave (
        input  RsD, RtD, TUseRsD, TUseRtD, RegWriteD, A3D, TNewD,
`ifdef MDU_STALL_EN
        input  MdD, MdStartE, MdBusyE,
`endif
        output Stall, FwdRsD, FwdRtD
    );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// -----------------------------------------------------------------------------
// hazard_match
// Combinational check of one D-stage source register against the E, M and W
// in-flight entries.
//   src, tuse          : source address and cycles until it is consumed
//   ent_e/ent_m/ent_w  : in-flight writer entries
//   stall              : some matching writer cannot deliver in time
//   fwd                : stage of the youngest matching writer if it is ready,
//                        otherwise FWD_RF
// -----------------------------------------------------------------------------
module hazard_match
    import hazard_scoreboard_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic [T_W-1:0]    tuse,
    input  stage_entry_t      ent_e,
    input  stage_entry_t      ent_m,
    input  stage_entry_t      ent_w,
    output logic              stall,
    output fwd_sel_e          fwd
);

    logic hit_e, hit_m, hit_w;
    logic used;

    // $0 is hard-wired, so a writer to it never creates a dependency.
    assign hit_e = ent_e.valid && (ent_e.a3 != '0) && (ent_e.a3 == src);
    assign hit_m = ent_m.valid && (ent_m.a3 != '0) && (ent_m.a3 == src);
    assign hit_w = ent_w.valid && (ent_w.a3 != '0) && (ent_w.a3 == src);
    assign used  = (tuse != TUSE_NONE);

    assign stall = used && ((hit_e && (ent_e.tnew > tuse)) ||
                            (hit_m && (ent_m.tnew > tuse)) ||
                            (hit_w && (ent_w.tnew > tuse)));

    // Only the youngest match may supply the operand; an older ready value
    // would be stale, so a not-yet-ready younger match falls back to FWD_RF.
    always_comb begin
        fwd = FWD_RF;
        if (hit_e) begin
            if (ent_e.tnew == '0) fwd = FWD_E;
        end else if (hit_m) begin
            if (ent_m.tnew == '0) fwd = FWD_M;
        end else if (hit_w) begin
            if (ent_w.tnew == '0) fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Tracks register writes in flight in E, M and W with a TNew countdown, stalls
// the D stage when a source operand cannot be produced in time and selects the
// D-stage forwarding source when the result already exists.
// Ports:
//   Clk    : clock
//   Reset  : synchronous, active-high; clears all stage entries
//   hif    : hazard_scoreboard_if.slave (D-stage request, Stall, FwdRsD/FwdRtD)
// Optional feature macro: MDU_STALL_EN -- also stall a D-stage mult/div/mfhi/
//   mflo/mthi/mtlo while the multiply/divide unit is starting or busy.
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    hazard_scoreboard_if.slave  hif
);

    stage_entry_t ent_e, ent_m, ent_w;
    stage_entry_t ent_d;
    logic         stall_rs, stall_rt;
    logic         stall_reg;
    logic         stall;
    fwd_sel_e     fwd_rs, fwd_rt;

    hazard_match u_match_rs (
        .src   (hif.RsD),
        .tuse  (hif.TUseRsD),
        .ent_e (ent_e),
        .ent_m (ent_m),
        .ent_w (ent_w),
        .stall (stall_rs),
        .fwd   (fwd_rs)
    );

    hazard_match u_match_rt (
        .src   (hif.RtD),
        .tuse  (hif.TUseRtD),
        .ent_e (ent_e),
        .ent_m (ent_m),
        .ent_w (ent_w),
        .stall (stall_rt),
        .fwd   (fwd_rt)
    );

    assign stall_reg = stall_rs || stall_rt;

`ifdef MDU_STALL_EN
    assign stall = stall_reg || (hif.MdD && (hif.MdStartE || hif.MdBusyE));
`else
    assign stall = stall_reg;
`endif

    assign hif.Stall  = stall;
    assign hif.FwdRsD = fwd_rs;
    assign hif.FwdRtD = fwd_rt;

    // Writes to $0 enter E as invalid so they never match later readers.
    always_comb begin
        ent_d.valid = hif.RegWriteD && (hif.A3D != '0);
        ent_d.a3    = hif.A3D;
        ent_d.tnew  = hif.TNewD;
    end

    // ---- D -> E -> M -> W advance ----
    // M and W always advance; a stall only replaces the E input with a bubble,
    // so the held D instruction is re-checked against the shifted entries.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ent_e <= '0;
            ent_m <= '0;
            ent_w <= '0;
        end else begin
            ent_w <= stage_advance(ent_m);
            ent_m <= stage_advance(ent_e);
            ent_e <= stall ? '0 : ent_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic Clk;
    logic Reset;

    hazard_scoreboard_if hif ();

    hazard_scoreboard dut (
        .Clk   (Clk),
        .Reset (Reset),
        .hif   (hif)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string      nm;
        logic       s;
        logic [1:0] frs;
        logic [1:0] frt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic md, md_start, md_busy;

    localparam logic [2:0] NU = 3'd7;

    // Apply one D-stage request for one cycle and record its expected response.
    task automatic drv(input string nm, input logic rst,
                       input logic [4:0] rs, input logic [2:0] trs,
                       input logic [4:0] rt, input logic [2:0] trt,
                       input logic rw, input logic [4:0] a3, input logic [2:0] tn,
                       input logic es, input logic [1:0] ers, input logic [1:0] ert);
        exp_t e;
        @(posedge Clk);
        #1;
        Reset         = rst;
        hif.RsD       = rs;
        hif.TUseRsD   = trs;
        hif.RtD       = rt;
        hif.TUseRtD   = trt;
        hif.RegWriteD = rw;
        hif.A3D       = a3;
        hif.TNewD     = tn;
`ifdef MDU_STALL_EN
        hif.MdD      = md;
        hif.MdStartE = md_start;
        hif.MdBusyE  = md_busy;
`endif
        e.nm  = nm;
        e.s   = es;
        e.frs = ers;
        e.frt = ert;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string nm);
        drv(nm, 1'b0, 5'd0, NU, 5'd0, NU, 1'b0, 5'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    endtask

    // Monitor: compares the combinational outputs mid-cycle against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (hif.Stall !== e.s) begin
                    n_fail++;
                    $display("FAIL %s Stall: got %b, expected %b", e.nm, hif.Stall, e.s);
                end
                n_checks++;
                if (hif.FwdRsD !== e.frs) begin
                    n_fail++;
                    $display("FAIL %s FwdRsD: got %0d, expected %0d", e.nm, hif.FwdRsD, e.frs);
                end
                n_checks++;
                if (hif.FwdRtD !== e.frt) begin
                    n_fail++;
                    $display("FAIL %s FwdRtD: got %0d, expected %0d", e.nm, hif.FwdRtD, e.frt);
                end
            end
        end
    end

    initial begin
        md = 1'b0; md_start = 1'b0; md_busy = 1'b0;
        Reset = 1'b1;
        hif.RsD = '0; hif.RtD = '0; hif.TUseRsD = NU; hif.TUseRtD = NU;
        hif.RegWriteD = 1'b0; hif.A3D = '0; hif.TNewD = '0;
`ifdef MDU_STALL_EN
        hif.MdD = 1'b0; hif.MdStartE = 1'b0; hif.MdBusyE = 1'b0;
`endif
        //  name          rst  rs  tRs  rt  tRt rw  a3  tn   S  Frs Frt
        drv("reset",      1,   0,  NU,  0,  NU, 0,  0,  0,   0, 0,  0);
        drv("reset2",     1,   0,  NU,  0,  NU, 0,  0,  0,   0, 0,  0);
        drv("no_writer",  0,   5,  0,   0,  NU, 0,  0,  0,   0, 0,  0);

        // lw $8 then beq $8: two stall cycles, then forward from W.
        drv("lw8",        0,   0,  NU,  0,  NU, 1,  8,  2,   0, 0,  0);
        drv("beq8_c1",    0,   8,  0,   0,  NU, 0,  0,  0,   1, 0,  0);
        drv("beq8_c2",    0,   8,  0,   0,  NU, 0,  0,  0,   1, 0,  0);
        drv("beq8_fwdW",  0,   8,  0,   0,  NU, 0,  0,  0,   0, 3,  0);
        idle("idle1");

        // add $9; add $10,$9 (TUse=1, no stall); beq $9 from M; both from M/W.
        drv("add9",       0,   0,  NU,  0,  NU, 1,  9,  1,   0, 0,  0);
        drv("add10_r9",   0,   9,  1,   0,  NU, 1, 10,  1,   0, 0,  0);
        drv("beq9_fwdM",  0,   9,  0,   0,  NU, 0,  0,  0,   0, 2,  0);
        drv("rs10_rt9",   0,  10,  0,   9,  0,  0,  0,  0,   0, 2,  3);
        idle("idle2");

        // Writers to $0 never create a dependency.
        drv("w0_a",       0,   0,  NU,  0,  NU, 1,  0,  2,   0, 0,  0);
        drv("w0_b_r0",    0,   0,  0,   0,  NU, 1,  0,  1,   0, 0,  0);
        drv("r0_both",    0,   0,  0,   0,  0,  0,  0,  0,   0, 0,  0);
        idle("idle3");

        // Two writers to $4: younger one not ready must block older ready one.
        drv("w4_old",     0,   0,  NU,  0,  NU, 1,  4,  1,   0, 0,  0);
        drv("w4_new",     0,   4,  NU,  4,  NU, 1,  4,  1,   0, 0,  0);
        drv("r4_stall",   0,   4,  0,   0,  NU, 0,  0,  0,   1, 0,  0);
        drv("r4_young",   0,   4,  0,   0,  NU, 0,  0,  0,   0, 2,  0);
        idle("idle4");

        // rt hazard: TUse=1 against TNew 2 stalls once, equal TNew does not.
        drv("w12",        0,   0,  NU,  0,  NU, 1, 12,  2,   0, 0,  0);
        drv("rt12_stall", 0,   0,  NU, 12,  1,  0,  0,  0,   1, 0,  0);
        drv("rt12_eq",    0,   0,  NU, 12,  1,  0,  0,  0,   0, 0,  0);
        drv("rt12_fwdW",  0,   0,  NU, 12,  0,  0,  0,  0,   0, 0,  3);
        idle("idle5");

        // Reset in the middle of a stall clears the in-flight writer.
        drv("w8_again",   0,   0,  NU,  0,  NU, 1,  8,  2,   0, 0,  0);
        drv("r8_stall",   0,   8,  0,   0,  NU, 0,  0,  0,   1, 0,  0);
        drv("r8_rst",     1,   8,  0,   0,  NU, 0,  0,  0,   1, 0,  0);
        drv("r8_after",   0,   8,  0,   0,  NU, 0,  0,  0,   0, 0,  0);
        idle("idle6");

`ifdef MDU_STALL_EN
        md = 1'b1; md_busy = 1'b1;
        for (int i = 0; i < 5; i++) idle("md_busy");
        md_busy = 1'b0;
        drv("md_free",    0,   0,  NU,  0,  NU, 0,  0,  0,   0, 0,  0);
        md_start = 1'b1;
        drv("md_start",   0,   0,  NU,  0,  NU, 0,  0,  0,   1, 0,  0);
        md = 1'b0;
        drv("md_notmd",   0,   0,  NU,  0,  NU, 0,  0,  0,   0, 0,  0);
        md = 1'b1; md_start = 1'b0; md_busy = 1'b1;
        drv("md_busy2",   1,   0,  NU,  0,  NU, 0,  0,  0,   1, 0,  0);
        md_busy = 1'b0;
        drv("md_rst_aft", 0,   0,  NU,  0,  NU, 0,  0,  0,   0, 0,  0);
        md = 1'b0;
        idle("idle7");
`endif

        // Let the monitor drain the queue within a fixed cycle budget.
        repeat (3) @(posedge Clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
